// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, peripheral and memory-side signals of the block RAM arbiter.
// master = requesters plus RAM (the environment); slave = the arbiter itself.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;

   logic          per_req;
   logic          per_we;
   logic [AW-1:0] per_addr;
   logic [DW-1:0] per_wdata;
   logic          per_gnt;
   logic [DW-1:0] per_rdata;
   logic          per_rvalid;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      output per_req, per_we, per_addr, per_wdata,
      input  per_gnt, per_rdata, per_rvalid,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      input  per_req, per_we, per_addr, per_wdata,
      output per_gnt, per_rdata, per_rvalid,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port block RAM between the CPU and a peripheral master.
// Default: CPU priority, peripheral forced ahead after MAX_WAIT denied cycles (MAX_WAIT=0: strict).
// Build option MEM_ARB_RR_EN: plain round-robin between the two requesters instead.
// Read data is a passthrough of the RAM; rvalid flags tag which owner the 1-cycle-late data belongs to.
module mem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4
) (
   input logic         clk,
   input logic         rst,
   mem_arbiter_if.slave bus
);

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   acc_t cpu_acc, per_acc, mem_acc;
   logic gnt_cpu, gnt_per;
   logic rd_cpu, rd_per;

   assign cpu_acc = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
   assign per_acc = '{we: bus.per_we, addr: bus.per_addr, wdata: bus.per_wdata};

`ifdef MEM_ARB_RR_EN
   // 1 = peripheral received the most recent grant; reads as CPU while rst is high
   logic rr_last;
   logic last_per;

   assign last_per = rr_last & ~rst;

   // grant: on contention the requester that did not win last time goes first
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_per = 1'b0;
      if (bus.cpu_req && bus.per_req) begin
         gnt_per = ~last_per;
         gnt_cpu = last_per;
      end else begin
         gnt_cpu = bus.cpu_req;
         gnt_per = bus.per_req;
      end
   end

   // remember the owner of every grant
   always_ff @(posedge clk) begin
      if (rst)                   rr_last <= 1'b0;
      else if (gnt_cpu | gnt_per) rr_last <= gnt_per;
   end
`else
   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

   logic [WW-1:0] wait_cnt;
   logic          aged;

   // counter is treated as zero during reset so the reset cycle arbitrates cleanly
   assign aged = (MAX_WAIT != 0) && !rst && (wait_cnt == WMAX);

   // grant: aged peripheral, then CPU, then peripheral
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_per = 1'b0;
      if (bus.per_req && aged) gnt_per = 1'b1;
      else if (bus.cpu_req)    gnt_cpu = 1'b1;
      else if (bus.per_req)    gnt_per = 1'b1;
   end

   // count consecutive denied peripheral cycles, saturating at MAX_WAIT
   always_ff @(posedge clk) begin
      if (rst || !bus.per_req || gnt_per) wait_cnt <= '0;
      else if (wait_cnt != WMAX)          wait_cnt <= wait_cnt + 1'b1;
   end
`endif

   // memory mux: idle cycles keep the CPU (fetch) address on the RAM with writes off
   always_comb begin
      mem_acc = '{we: 1'b0, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
      if (gnt_per)      mem_acc = per_acc;
      else if (gnt_cpu) mem_acc = cpu_acc;
   end

   assign bus.mem_addr  = mem_acc.addr;
   assign bus.mem_we    = mem_acc.we;
   assign bus.mem_wdata = mem_acc.wdata;

   assign bus.per_gnt   = gnt_per;
   assign bus.cpu_stall = bus.cpu_req & ~gnt_cpu;

   // tag next cycle's RAM data with the owner of this cycle's granted read
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cpu <= 1'b0;
         rd_per <= 1'b0;
      end else begin
         rd_cpu <= gnt_cpu & ~bus.cpu_we;
         rd_per <= gnt_per & ~bus.per_we;
      end
   end

   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.per_rdata  = bus.mem_rdata;
   assign bus.cpu_rvalid = rd_cpu & ~rst;
   assign bus.per_rvalid = rd_per & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) bus_s ();

   mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(0))  dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

   // strict-priority instance sees the same requests
   assign bus_s.cpu_req   = bus.cpu_req;
   assign bus_s.cpu_we    = bus.cpu_we;
   assign bus_s.cpu_addr  = bus.cpu_addr;
   assign bus_s.cpu_wdata = bus.cpu_wdata;
   assign bus_s.per_req   = bus.per_req;
   assign bus_s.per_we    = bus.per_we;
   assign bus_s.per_addr  = bus.per_addr;
   assign bus_s.per_wdata = bus.per_wdata;
   assign bus_s.mem_rdata = bus.mem_rdata;

   function automatic logic [15:0] dflt(logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   // block RAM: 1-cycle read latency, read-before-write, unwritten words read dflt(addr)
   logic [15:0] ram   [65536];
   bit          ram_v [65536];
   always @(posedge clk) begin
      bus.mem_rdata <= ram_v[bus.mem_addr] ? ram[bus.mem_addr] : dflt(bus.mem_addr);
      if (bus.mem_we) begin
         ram[bus.mem_addr]   <= bus.mem_wdata;
         ram_v[bus.mem_addr] <= 1'b1;
      end
   end

   // ---------------- reference model (transaction level) ----------------
   // owner of this cycle: 0 none, 1 CPU, 2 peripheral
   int          exp_g;
   int          m_wait;       // cycles the peripheral has been refused in a row
   bit          m_last_per;   // peripheral owned the last grant
   bit          exp_rv_cpu, exp_rv_per;
   logic [15:0] exp_rdat;
   logic [15:0] sh   [65536];
   bit          sh_v [65536];

   function automatic int pick(bit c, bit p, bit r, int w, bit lp);
`ifdef MEM_ARB_RR_EN
      bit l;
      l = lp && !r;
      if (c && p) return l ? 1 : 2;
`else
      if (p && MW != 0 && !r && w >= MW) return 2;
`endif
      if (c) return 1;
      if (p) return 2;
      return 0;
   endfunction

   always_comb exp_g = pick(bus.cpu_req, bus.per_req, rst, m_wait, m_last_per);

   always @(posedge clk) begin
      if (rst) begin
         m_wait     <= 0;
         m_last_per <= 1'b0;
         exp_rv_cpu <= 1'b0;
         exp_rv_per <= 1'b0;
      end else begin
         exp_rv_cpu <= (exp_g == 1) && !bus.cpu_we;
         exp_rv_per <= (exp_g == 2) && !bus.per_we;
         if (exp_g == 2 || !bus.per_req) m_wait <= 0;
         else if (m_wait < MW)           m_wait <= m_wait + 1;
         if (exp_g != 0) m_last_per <= (exp_g == 2);
      end
      if (exp_g == 1) exp_rdat <= sh_v[bus.cpu_addr] ? sh[bus.cpu_addr] : dflt(bus.cpu_addr);
      if (exp_g == 2) exp_rdat <= sh_v[bus.per_addr] ? sh[bus.per_addr] : dflt(bus.per_addr);
      if (exp_g == 1 && bus.cpu_we) begin sh[bus.cpu_addr] <= bus.cpu_wdata; sh_v[bus.cpu_addr] <= 1'b1; end
      if (exp_g == 2 && bus.per_we) begin sh[bus.per_addr] <= bus.per_wdata; sh_v[bus.per_addr] <= 1'b1; end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit cr, bit cw, logic [15:0] ca, logic [15:0] cd,
                        bit pr, bit pw, logic [15:0] pa, logic [15:0] pd);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.per_req = pr; bus.per_we = pw; bus.per_addr = pa; bus.per_wdata = pd;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 16'h1111, 16'h2222, 0, 0, 16'h3333, 16'h4444);
      @(negedge clk);
      checks++; if (bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rst_cpu_rvalid got=%b want=0", bus.cpu_rvalid); end
      checks++; if (bus.per_rvalid !== 1'b0) begin failures++; $display("FAIL rst_per_rvalid got=%b want=0", bus.per_rvalid); end
      checks++; if (bus.per_gnt !== 1'b0) begin failures++; $display("FAIL rst_per_gnt got=%b want=0", bus.per_gnt); end
      checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); end
      checks++; if (bus.mem_addr !== 16'h1111) begin failures++; $display("FAIL rst_idle_addr got=%h want=1111", bus.mem_addr); end
      tick();
      drive(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_cpu_stall got=%b want=0", bus.cpu_stall); end
      checks++; if (bus.mem_addr !== 16'h0020) begin failures++; $display("FAIL rst_cpu_addr got=%h want=0020", bus.mem_addr); end
      tick();
      rst = 1'b0;
      drive(0, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rst_read_no_rvalid got=%b want=0", bus.cpu_rvalid); end
      tick();
   endtask

   task automatic test_cpu_only();
      drive(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL cpu_wr_we got=%b want=1", bus.mem_we); end
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
         @(negedge clk);
         checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL cpu_stall k=%0d got=%b want=0", k, bus.cpu_stall); end
         checks++; if (bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL cpu_addr k=%0d got=%h want=0010", k, bus.mem_addr); end
         checks++; if (bus.per_rvalid !== 1'b0) begin failures++; $display("FAIL cpu_per_rvalid k=%0d got=%b want=0", k, bus.per_rvalid); end
         checks++; if (bus.cpu_rvalid !== (k != 0)) begin failures++; $display("FAIL cpu_rvalid k=%0d got=%b want=%b", k, bus.cpu_rvalid, k != 0); end
         if (k != 0) begin
            checks++; if (bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL cpu_rdata k=%0d got=%h want=1234", k, bus.cpu_rdata); end
         end
         tick();
      end
      drive(0, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL cpu_last_read got=%b/%h want=1/1234", bus.cpu_rvalid, bus.cpu_rdata); end
      tick();
   endtask

   task automatic test_per_write();
      drive(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h8000, 16'hBEEF);
      @(negedge clk);
      checks++; if (bus.per_gnt !== 1'b1) begin failures++; $display("FAIL pw_gnt got=%b want=1", bus.per_gnt); end
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL pw_we got=%b want=1", bus.mem_we); end
      checks++; if (bus.mem_addr !== 16'h8000) begin failures++; $display("FAIL pw_addr got=%h want=8000", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL pw_wdata got=%h want=beef", bus.mem_wdata); end
      tick();
      drive(1, 0, 16'h8000, 16'h0000, 0, 0, 16'h8000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.per_rvalid !== 1'b0) begin failures++; $display("FAIL pw_no_rvalid got=%b want=0", bus.per_rvalid); end
      tick();
      drive(0, 0, 16'h8000, 16'h0000, 0, 0, 16'h8000, 16'h0000);
      @(negedge clk);
      checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL pw_readback got=%b/%h want=1/beef", bus.cpu_rvalid, bus.cpu_rdata); end
      tick();
   endtask

`ifndef MEM_ARB_RR_EN
   task automatic test_aging();
      bit e, pe;
      for (int k = 0; k < 12; k++) begin
         drive(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000);
         e  = (k % 5 == 4);
         pe = (k > 0) && ((k - 1) % 5 == 4);
         @(negedge clk);
         checks++; if (bus.per_gnt !== e) begin failures++; $display("FAIL age_gnt k=%0d got=%b want=%b", k, bus.per_gnt, e); end
         checks++; if (bus.cpu_stall !== e) begin failures++; $display("FAIL age_stall k=%0d got=%b want=%b", k, bus.cpu_stall, e); end
         checks++; if (bus.mem_addr !== (e ? 16'h0200 : 16'h0100)) begin failures++; $display("FAIL age_addr k=%0d got=%h", k, bus.mem_addr); end
         if (k > 0) begin
            checks++; if (bus.per_rvalid !== pe || bus.cpu_rvalid !== !pe) begin failures++; $display("FAIL age_rvalid k=%0d got=%b%b want=%b%b", k, bus.cpu_rvalid, bus.per_rvalid, !pe, pe); end
         end
         if (pe) begin
            checks++; if (bus.per_rdata !== (16'h0200 ^ 16'hA5C3)) begin failures++; $display("FAIL age_rdata k=%0d got=%h", k, bus.per_rdata); end
         end
         tick();
      end
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
   endtask

   task automatic test_strict();
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000);
         @(negedge clk);
         checks++; if (bus_s.per_gnt !== 1'b0 || bus_s.cpu_stall !== 1'b0) begin failures++; $display("FAIL strict k=%0d gnt=%b stall=%b want=0/0", k, bus_s.per_gnt, bus_s.cpu_stall); end
         tick();
      end
      drive(0, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000);
      @(negedge clk);
      checks++; if (bus_s.per_gnt !== 1'b1) begin failures++; $display("FAIL strict_release got=%b want=1", bus_s.per_gnt); end
      tick();
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 16'h0100, 16'h0000, 1, 0, 16'h0300, 16'h0000);
      @(negedge clk);
      checks++; if (bus.per_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b want=1", bus.per_gnt); end
      tick();
      rst = 1'b1;
      drive(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0300, 16'h0000);
      @(negedge clk);
      checks++; if (bus.per_rvalid !== 1'b0) begin failures++; $display("FAIL rm_rvalid_rst got=%b want=0", bus.per_rvalid); end
      checks++; if (bus.cpu_stall !== 1'b0) begin failures++; $display("FAIL rm_rst_cpu got=%b want=0", bus.cpu_stall); end
      tick();
      rst = 1'b0;
      drive(0, 0, 16'h0100, 16'h0000, 0, 0, 16'h0300, 16'h0000);
      @(negedge clk);
      checks++; if (bus.per_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rm_rvalid_after got=%b%b want=00", bus.cpu_rvalid, bus.per_rvalid); end
      tick();
      // build up three denied cycles, then reset while contended
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0300, 16'h0000);
         tick();
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.per_gnt !== 1'b0) begin failures++; $display("FAIL rm_rst_contend got=%b want=0", bus.per_gnt); end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (bus.per_gnt !== (k == 4)) begin failures++; $display("FAIL rm_after k=%0d got=%b want=%b", k, bus.per_gnt, k == 4); end
         tick();
      end
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
   endtask
`else
   task automatic test_rr();
      bit e;
      rst = 1'b1;
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000);
         e = (k % 2 == 0);
         @(negedge clk);
         checks++; if (bus.per_gnt !== e || bus.cpu_stall !== e) begin failures++; $display("FAIL rr k=%0d gnt=%b stall=%b want=%b", k, bus.per_gnt, bus.cpu_stall, e); end
         if (k > 0) begin
            checks++; if (bus.per_rvalid !== !e || bus.cpu_rvalid !== e) begin failures++; $display("FAIL rr_rvalid k=%0d got=%b%b want=%b%b", k, bus.cpu_rvalid, bus.per_rvalid, e, !e); end
         end
         tick();
      end
      // a lone requester is always served even if it owned the last grant
      drive(0, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000);
      tick();
      @(negedge clk);
      checks++; if (bus.per_gnt !== 1'b1) begin failures++; $display("FAIL rr_single got=%b want=1", bus.per_gnt); end
      tick();
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
   endtask
`endif

   task automatic test_random();
      bit          cp = 0, pp = 0, cw = 0, pw = 0, cdone, pdone;
      logic [15:0] ca = '0, cd = '0, pa = '0, pd = '0;
      logic [15:0] ea, ed;
      bit          ewe;
      for (int k = 0; k < 400; k++) begin
         if (!cp && $urandom_range(0, 9) < 7) begin
            cp = 1; cw = $urandom_range(0, 1); ca = 16'($urandom_range(0, 31)); cd = 16'($urandom);
         end
         if (!pp && $urandom_range(0, 9) < 6) begin
            pp = 1; pw = $urandom_range(0, 1); pa = 16'($urandom_range(0, 31)); pd = 16'($urandom);
         end
         rst = ($urandom_range(0, 49) == 0);
         drive(cp, cw, ca, cd, pp, pw, pa, pd);
         @(negedge clk);
         ea  = (exp_g == 2) ? pa : ca;
         ed  = (exp_g == 2) ? pd : cd;
         ewe = (exp_g == 2) ? pw : ((exp_g == 1) ? cw : 1'b0);
         checks++; if (bus.per_gnt !== (exp_g == 2)) begin failures++; $display("FAIL rnd_gnt k=%0d got=%b want=%b", k, bus.per_gnt, exp_g == 2); end
         checks++; if (bus.cpu_stall !== (cp && exp_g != 1)) begin failures++; $display("FAIL rnd_stall k=%0d got=%b want=%b", k, bus.cpu_stall, cp && exp_g != 1); end
         checks++; if (bus.mem_we !== ewe || bus.mem_addr !== ea || bus.mem_wdata !== ed) begin failures++; $display("FAIL rnd_mem k=%0d got=%b/%h/%h want=%b/%h/%h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, ewe, ea, ed); end
         checks++; if (bus.cpu_rvalid !== (exp_rv_cpu && !rst) || bus.per_rvalid !== (exp_rv_per && !rst)) begin failures++; $display("FAIL rnd_rvalid k=%0d got=%b%b want=%b%b", k, bus.cpu_rvalid, bus.per_rvalid, exp_rv_cpu && !rst, exp_rv_per && !rst); end
         if (exp_rv_cpu && !rst) begin
            checks++; if (bus.cpu_rdata !== exp_rdat) begin failures++; $display("FAIL rnd_cpu_rdata k=%0d got=%h want=%h", k, bus.cpu_rdata, exp_rdat); end
         end
         if (exp_rv_per && !rst) begin
            checks++; if (bus.per_rdata !== exp_rdat) begin failures++; $display("FAIL rnd_per_rdata k=%0d got=%h want=%h", k, bus.per_rdata, exp_rdat); end
         end
         cdone = (exp_g == 1);
         pdone = (exp_g == 2);
         tick();
         if (cdone) cp = 0;
         if (pdone) pp = 0;
      end
      rst = 1'b0;
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      test_reset();
      test_cpu_only();
      test_per_write();
`ifndef MEM_ARB_RR_EN
      test_aging();
      test_strict();
      test_reset_mid();
`else
      test_rr();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
